// File: rtl/scazator_serial.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// LSB first. The per-bit cell is two half-subtractors feeding a registered
// borrow flip-flop. Start/busy/done handshake; results hold until the next
// completion.
//
// Handshake: start is sampled only in IDLE; the accepting edge captures a and b,
// after which both may change freely. busy is high for the WIDTH cycles of RUN,
// done is a one-cycle pulse in DONE, and the two are never high together.
// A start seen in RUN or DONE is dropped, not queued.
module scazator_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             a_msb;
   logic             b_msb;

   logic             x;
   logic             y;
   logic             d1;
   logic             b1;
   logic             d;
   logic             b2;
   logic             last;

   // Full-subtractor cell on the current LSBs plus the stored borrow.
   always_comb begin
      x        = sa[0];
      y        = sb[0];
      d1       = x ^ y;
      b1       = ~x & y;
      d        = d1 ^ br;
      b2       = ~d1 & br;
      res_next = {d, res[WIDTH-1:1]};
      last     = (cnt == CW'(WIDTH - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand capture, bit-serial shifting, result publication on the last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sa         <= '0;
         sb         <= '0;
         res        <= '0;
         cnt        <= '0;
         br         <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
               end
            end
            RUN: begin
               res <= res_next;
               br  <= b1 | b2;
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               cnt <= cnt + 1'b1;
               if (last) begin
                  // Published on the edge entering DONE so they are valid with the done pulse.
                  diff       <= res_next;
                  borrow_out <= b1 | b2;
                  ovf        <= (a_msb != b_msb) & (res_next[WIDTH-1] != a_msb);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
